edge_extractor: RTL and testbench
=================================

// Module: edge_extractor
// PURPOSE
//   Edge extractor for one asynchronous single-bit level input. Synchronizes in_s
//   into the clk domain and emits one-clock pulses on its edges:
//   out_s1 on a rising edge (input goes to 1), out_s0 on a falling edge (input goes to 0).
//   Sits at the design top, between an external pin/level and synchronous logic.
// PARAMETERS
//   SYNC_STAGES    2   flip-flops in the input synchronizer chain; legal range 2..4
//   FILTER_CYCLES  4   glitch-filter stability window in clocks (EDGE_FILTER_EN only); >=1
// PORTS
//   clk     input  1  system clock, 50 MHz nominal, all logic on rising edge
//   rst_n   input  1  synchronous active-low reset
//   in_s    input  1  asynchronous level input
//   out_s0  output 1  falling-edge pulse, registered, high exactly 1 clk
//   out_s1  output 1  rising-edge pulse, registered, high exactly 1 clk
// BEHAVIOUR
//   - Interface: one clock, clk; reset is synchronous and active-low, rst_n.
//   - Reset (rst_n=0 at a clk edge): sync chain, history flop, filter state and both
//     outputs cleared to 0. During reset the input is treated as 0.
//   - After reset release with in_s already 1: treated as a rising edge, one out_s1 pulse.
//   - Sync: in_s passes through SYNC_STAGES flops; last stage = s. History flop p <= s.
//   - out_s1 <= s & ~p; out_s0 <= ~s & p (both registered).
//   - Latency: if in_s changes before clk edge k (setup met), the pulse is high in
//     the cycle starting at edge k+SYNC_STAGES and low again at edge k+SYNC_STAGES+1.
//   - out_s0 and out_s1 are mutually exclusive; never high in the same cycle.
//   - Each accepted transition produces exactly one pulse. A constant input produces no pulses.
//   - Input toggling every clock (no filter): alternating s1/s0 pulses, one per
//     transition, each delayed by the same latency.
//   - Input pulse shorter than 1 clk: may be missed (no capture guarantee).
//   - rst_n asserted mid-pulse: outputs 0 at the next edge. No pulse is generated
//     for the reset itself.
// CONFIGURATION
//   EDGE_FILTER_EN defined:
//     - A glitch filter sits between s and the history flop. The filtered level f
//       changes only after s has held the new value for FILTER_CYCLES consecutive clocks.
//     - The counter restarts whenever s returns to the current f.
//     - Edge logic uses f in place of s. Added latency is FILTER_CYCLES clocks.
//     - Excursions shorter than FILTER_CYCLES clocks produce no pulse.
//     - The counter resets to 0 and f resets to 0.
//   EDGE_FILTER_EN undefined: no filter logic; FILTER_CYCLES is ignored; latency as above.
// TESTING  (20 ns clk, SYNC_STAGES=2, synchronous checks)
//   - rst_n=0 for 3 clks, in_s=0 -> out_s0=out_s1=0 throughout and after release.
//   - in_s 0 for 20 clks, then 1 for 20, then 0 for 20 -> out_s1=1 for exactly one
//     clk 2 clks after the rise; out_s0=1 for one clk 2 clks after the fall; no other pulses.
//   - in_s=1 during reset, release rst_n -> single out_s1 pulse 2 clks after release, out_s0=0.
//   - in_s toggles every clk for 8 clks -> 8 alternating pulses (s1,s0,...), never both high.
//   - rst_n=0 on the cycle out_s1 is high -> out_s1=0 at next edge; no pulse after release if in_s unchanged... 
//     (in_s=1 held: one out_s1 after release, per reset rule).
//   - EDGE_FILTER_EN, FILTER_CYCLES=4: 3-clk high glitch -> no pulse; 4-clk high ->
//     one out_s1 at 2+4 clks after the rise, then one out_s0 after the fall.

Source files
------------

// File: rtl/edge_extractor_if.sv
// rtl/edge_extractor_if.sv - level input and edge-pulse outputs of edge_extractor
//   in_s    : asynchronous level input (driven by master)
//   out_s0  : falling-edge pulse, one clk (driven by slave)
//   out_s1  : rising-edge pulse, one clk (driven by slave)
interface edge_extractor_if;
  logic in_s;
  logic out_s0;
  logic out_s1;

  modport master (
    output in_s,
    input  out_s0,
    input  out_s1
  );

  modport slave (
    input  in_s,
    output out_s0,
    output out_s1
  );
endinterface

// File: rtl/edge_extractor.sv
// rtl/edge_extractor.sv - synchronizes one async level and emits one-clk edge pulses
//   clk      : system clock, rising edge
//   rst_n    : synchronous active-low reset
//   edge_if  : slave modport (in_s in, out_s0/out_s1 registered pulses out)
//   Optional glitch filter enabled by defining EDGE_FILTER_EN.
//   SYNC_STAGES   : synchronizer depth, 2..4
//   FILTER_CYCLES : filter stability window in clocks, >= 1 (filter build only)
module edge_extractor #(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  edge_extractor_if.slave edge_if
);

  generate
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || FILTER_CYCLES < 1) begin : g_bad_param
      $error("edge_extractor: SYNC_STAGES must be 2..4 and FILTER_CYCLES >= 1");
    end
  endgenerate

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   p_q, p_d;
  logic                   out_s0_q, out_s0_d;
  logic                   out_s1_q, out_s1_d;
  logic                   s;
  logic                   level;

  assign s = sync_q[SYNC_STAGES-1];

`ifdef EDGE_FILTER_EN
  localparam int CW = $clog2(FILTER_CYCLES + 1);

  logic          f_q, f_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // f follows s only once s has differed from f for FILTER_CYCLES
  // consecutive clocks; any return to f restarts the count.
  always_comb begin
    f_d   = f_q;
    cnt_d = '0;
    if (s != f_q) begin
      if (cnt_q == CW'(FILTER_CYCLES - 1)) begin
        f_d = s;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      f_q   <= 1'b0;
      cnt_q <= '0;
    end else begin
      f_q   <= f_d;
      cnt_q <= cnt_d;
    end
  end

  assign level = f_q;
`else
  assign level = s;
`endif

  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], edge_if.in_s};
    p_d      = level;
    out_s1_d = level & ~p_q;
    out_s0_d = ~level & p_q;
  end

  // Clearing the whole chain and history makes the input look like 0 during
  // reset, so a level already high at release produces one rising pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q   <= '0;
      p_q      <= 1'b0;
      out_s0_q <= 1'b0;
      out_s1_q <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      p_q      <= p_d;
      out_s0_q <= out_s0_d;
      out_s1_q <= out_s1_d;
    end
  end

  assign edge_if.out_s0 = out_s0_q;
  assign edge_if.out_s1 = out_s1_q;

endmodule

// File: tb/tb_edge_extractor.sv
// tb/tb_edge_extractor.sv - directed self-checking bench for edge_extractor
module tb_edge_extractor;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  edge_extractor_if eif ();

  edge_extractor #(
    .SYNC_STAGES   (2),
    .FILTER_CYCLES (4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .edge_if (eif)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check_bit(input string tag, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%b expected=%b at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock edge, then sample 1 ns later; inputs change here too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    eif.in_s = 1'b0;

    // Reset with input low: quiet throughout and after release.
    for (int i = 1; i <= 3; i++) begin
      tick();
      check_bit("rst_lo_s0", eif.out_s0, 1'b0);
      check_bit("rst_lo_s1", eif.out_s1, 1'b0);
    end
    rst_n = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      check_bit("idle_s0", eif.out_s0, 1'b0);
      check_bit("idle_s1", eif.out_s1, 1'b0);
    end

`ifndef EDGE_FILTER_EN
    // Rise: pulse on the third sampled edge after the change, only once.
    eif.in_s = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      check_bit("rise_s1", eif.out_s1, i == 3);
      check_bit("rise_s0", eif.out_s0, 1'b0);
    end
    eif.in_s = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      check_bit("fall_s0", eif.out_s0, i == 3);
      check_bit("fall_s1", eif.out_s1, 1'b0);
    end

    // Input high while in reset: single rising pulse after release.
    rst_n    = 1'b0;
    eif.in_s = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check_bit("rst_hi_s1", eif.out_s1, 1'b0);
      check_bit("rst_hi_s0", eif.out_s0, 1'b0);
    end
    rst_n = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      check_bit("rel_hi_s1", eif.out_s1, i == 3);
      check_bit("rel_hi_s0", eif.out_s0, 1'b0);
    end

    // Settle low, then toggle every clock for 8 clocks.
    eif.in_s = 1'b0;
    for (int i = 1; i <= 6; i++) tick();
    for (int i = 1; i <= 12; i++) begin
      if (i <= 8) eif.in_s = ~eif.in_s;
      tick();
      check_bit("tog_s1", eif.out_s1, (i >= 3) && (i <= 10) && (i % 2 == 1));
      check_bit("tog_s0", eif.out_s0, (i >= 3) && (i <= 10) && (i % 2 == 0));
      check_bit("tog_excl", eif.out_s0 & eif.out_s1, 1'b0);
    end

    // Reset asserted while out_s1 is high.
    for (int i = 1; i <= 4; i++) tick();
    eif.in_s = 1'b1;
    tick();
    tick();
    tick();
    check_bit("mid_pre_s1", eif.out_s1, 1'b1);
    rst_n = 1'b0;
    tick();
    check_bit("mid_rst_s1", eif.out_s1, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      check_bit("mid_rel_s1", eif.out_s1, i == 3);
      check_bit("mid_rel_s0", eif.out_s0, 1'b0);
    end
`else
    // 3-clock glitch: filtered out entirely.
    for (int i = 1; i <= 16; i++) begin
      eif.in_s = (i <= 3);
      tick();
      check_bit("glitch_s1", eif.out_s1, 1'b0);
      check_bit("glitch_s0", eif.out_s0, 1'b0);
    end
    // 4-clock pulse: rise pulse at 2+4 after rise, fall pulse at 2+4 after fall.
    for (int i = 1; i <= 20; i++) begin
      eif.in_s = (i <= 4);
      tick();
      check_bit("filt_s1", eif.out_s1, i == 7);
      check_bit("filt_s0", eif.out_s0, i == 11);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
